// File: rtl/atctlc2axi500_rr_mux_reg.sv
// atctlc2axi500_rr_mux_reg: round-robin valid/ready arbiter-mux with optional burst lock and a registered output slice
module atctlc2axi500_rr_mux_reg #(
    parameter int N = 2,
    parameter int W = 8,
    parameter bit LOCK = 0
) (
    input  logic           aclk,
    input  logic           aresetn,
    input  logic [N-1:0]   in_valid,
    output logic [N-1:0]   in_ready,
    input  logic [N*W-1:0] in_data,
    input  logic [N-1:0]   in_last,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [W-1:0]   out_data,
    output logic           out_last,
    output logic [N-1:0]   out_grant
);
    localparam logic [N-1:0] ONE = N'(1);
    logic [N-1:0] ptr_q, ptr_d, lown_q, lown_d, out_grant_q, out_grant_d;
    logic [N-1:0] gnt, gnt_rr, hi, pick, rot;
    logic [W-1:0] sel_data, out_data_q, out_data_d;
    logic lck_q, lck_d, out_valid_q, out_valid_d, out_last_q, out_last_d;
    logic free, acc, sel_last;
    always_comb begin
        // requests at or above the pointer win; otherwise wrap to the lowest one
        hi = in_valid & ~(ptr_q - ONE);
        pick = (|hi) ? hi : in_valid;
        gnt_rr = pick & (~pick + ONE);
        gnt = (LOCK && lck_q) ? (lown_q & in_valid) : gnt_rr;
        free = ~out_valid_q | out_ready;
        acc = (|(in_valid & gnt)) & free;
        sel_data = '0;
        for (int i = 0; i < N; i++) sel_data |= gnt[i] ? in_data[i*W +: W] : '0;
        sel_last = |(gnt & in_last);
        rot = (gnt << 1) | (gnt >> (N - 1));
        out_valid_d = acc | (out_valid_q & ~out_ready);
        out_data_d = acc ? sel_data : out_data_q;
        out_last_d = acc ? sel_last : out_last_q;
        out_grant_d = acc ? gnt : out_grant_q;
        ptr_d = (acc && (!LOCK || sel_last)) ? rot : ptr_q;
        lck_d = LOCK && (acc ? ~sel_last : lck_q);
        lown_d = (LOCK && acc && !lck_q && !sel_last) ? gnt : lown_q;
    end
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            ptr_q <= ONE;
            lck_q <= 1'b0;
            lown_q <= '0;
            out_valid_q <= 1'b0;
            out_data_q <= '0;
            out_last_q <= 1'b0;
            out_grant_q <= '0;
        end else begin
            ptr_q <= ptr_d;
            lck_q <= lck_d;
            lown_q <= lown_d;
            out_valid_q <= out_valid_d;
            out_data_q <= out_data_d;
            out_last_q <= out_last_d;
            out_grant_q <= out_grant_d;
        end
    end
    assign in_ready = gnt & {N{free}};
    assign out_valid = out_valid_q;
    assign out_data = out_data_q;
    assign out_last = out_last_q;
    assign out_grant = out_grant_q;
    assert property (@(posedge aclk) disable iff (!aresetn) $onehot0(gnt));
    assert property (@(posedge aclk) disable iff (!aresetn)
        out_valid_q && !out_ready |=> $stable(out_data_q) && $stable(out_last_q) && $stable(out_grant_q));
    assert property (@(posedge aclk) disable iff (!aresetn) !free |-> in_ready == '0);
endmodule

// File: tb/tb_atctlc2axi500_rr_mux_reg.sv
// tb_atctlc2axi500_rr_mux_reg: directed and random checks of the arbiter-mux against an integer-level model
module tb_atctlc2axi500_rr_mux_reg;
    logic aclk = 0, aresetn = 0;
    always #5 aclk = ~aclk;
    logic [3:0] iv[2], ir[2], il[2], og[2];
    logic [31:0] id[2];
    logic ov[2], ordy[2], ol[2];
    logic [7:0] od[2];
    logic iv1, ir1, il1, ov1, ordy1, ol1, og1;
    logic [31:0] id1, od1;
    int checks = 0, errors = 0;
    int mp[2], mo[2], mg[2];
    bit mlk[2], mv[2], ml[2];
    logic [7:0] md[2];
    bit mv1, ml1, mg1, acc1, del1;
    logic [31:0] md1, deld1;
    logic [31:0] q[$], rx[$];

    atctlc2axi500_rr_mux_reg #(.N(4), .W(8), .LOCK(0)) d0 (.aclk(aclk), .aresetn(aresetn), .in_valid(iv[0]),
        .in_ready(ir[0]), .in_data(id[0]), .in_last(il[0]), .out_valid(ov[0]), .out_ready(ordy[0]),
        .out_data(od[0]), .out_last(ol[0]), .out_grant(og[0]));
    atctlc2axi500_rr_mux_reg #(.N(4), .W(8), .LOCK(1)) d1 (.aclk(aclk), .aresetn(aresetn), .in_valid(iv[1]),
        .in_ready(ir[1]), .in_data(id[1]), .in_last(il[1]), .out_valid(ov[1]), .out_ready(ordy[1]),
        .out_data(od[1]), .out_last(ol[1]), .out_grant(og[1]));
    atctlc2axi500_rr_mux_reg #(.N(1), .W(32), .LOCK(0)) d2 (.aclk(aclk), .aresetn(aresetn), .in_valid(iv1),
        .in_ready(ir1), .in_data(id1), .in_last(il1), .out_valid(ov1), .out_ready(ordy1),
        .out_data(od1), .out_last(ol1), .out_grant(og1));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] oh(input int g);
        return g < 0 ? 4'b0 : 4'(1 << g);
    endfunction

    function automatic int grant(input int m);
        if (m == 1 && mlk[m]) return iv[m][mo[m]] ? mo[m] : -1;
        for (int k = 0; k < 4; k++) if (iv[m][(mp[m] + k) % 4]) return (mp[m] + k) % 4;
        return -1;
    endfunction

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            mp[m] = 0; mo[m] = 0; mg[m] = -1; mlk[m] = 0; mv[m] = 0; ml[m] = 0; md[m] = 0;
        end
        mv1 = 0; ml1 = 0; mg1 = 0; md1 = 0;
    endtask

    // compare at the falling edge, then advance the model across the rising edge
    task automatic cyc();
        int g[2];
        bit a[2];
        @(negedge aclk);
        for (int m = 0; m < 2; m++) begin
            g[m] = grant(m);
            a[m] = g[m] >= 0 && (!mv[m] || ordy[m]);
            chk($sformatf("in_ready%0d", m), ir[m], a[m] ? oh(g[m]) : 4'b0);
            chk($sformatf("out_valid%0d", m), ov[m], mv[m]);
            chk($sformatf("out_data%0d", m), od[m], md[m]);
            chk($sformatf("out_last%0d", m), ol[m], ml[m]);
            chk($sformatf("out_grant%0d", m), og[m], oh(mg[m]));
        end
        acc1 = iv1 && (!mv1 || ordy1);
        del1 = ov1 && ordy1;
        deld1 = od1;
        chk("n1_in_ready", ir1, acc1);
        chk("n1_out_valid", ov1, mv1);
        chk("n1_out_data", od1, md1);
        chk("n1_out_last", ol1, ml1);
        chk("n1_out_grant", og1, mg1);
        @(posedge aclk);
        for (int m = 0; m < 2; m++) begin
            if (a[m]) begin
                mv[m] = 1; md[m] = id[m][g[m]*8 +: 8]; ml[m] = il[m][g[m]]; mg[m] = g[m];
                if (m == 0 || ml[m]) mp[m] = (g[m] + 1) % 4;
                if (m == 1) begin
                    if (ml[m]) mlk[m] = 0;
                    else if (!mlk[m]) begin mlk[m] = 1; mo[m] = g[m]; end
                end
            end else if (mv[m] && ordy[m]) mv[m] = 0;
        end
        if (acc1) begin mv1 = 1; md1 = id1; ml1 = il1; mg1 = 1; end
        else if (mv1 && ordy1) mv1 = 0;
        #1;
    endtask

    initial begin
        for (int m = 0; m < 2; m++) begin iv[m] = 0; id[m] = 0; il[m] = 0; ordy[m] = 1; end
        iv1 = 0; id1 = 0; il1 = 0; ordy1 = 0;
        model_reset();
        #12;
        for (int m = 0; m < 2; m++) begin
            chk("rst_out_valid", ov[m], 0);
            chk("rst_out_data", od[m], 0);
            chk("rst_out_last", ol[m], 0);
            chk("rst_out_grant", og[m], 0);
        end
        chk("rst_ptr", d1.ptr_q, 4'b0001);
        chk("rst_n1_out_valid", ov1, 0);
        aresetn = 1;
        @(posedge aclk); #1;
        // full request, round-robin rotation with no bubbles
        iv[0] = 4'hF; id[0] = 32'hA3A2A1A0;
        for (int k = 0; k < 8; k++) begin
            cyc();
            chk("rr_valid", ov[0], 1);
            chk("rr_data", od[0], 8'hA0 + k % 4);
            chk("rr_grant", og[0], oh(k % 4));
        end
        // back-pressure hold
        iv[0] = 4'b0100; id[0] = 32'h005C0000;
        cyc();
        chk("bp_first", od[0], 8'h5C);
        ordy[0] = 0;
        for (int k = 0; k < 3; k++) begin
            #1 chk("bp_in_ready", ir[0], 0);
            cyc();
            chk("bp_valid", ov[0], 1);
            chk("bp_data", od[0], 8'h5C);
        end
        iv[0] = 0; ordy[0] = 1;
        cyc();
        chk("bp_popped", ov[0], 0);
        cyc();
        // locked burst on channel 1 while channel 3 waits
        iv[1] = 4'b1010; id[1] = 32'h33000000; il[1] = 4'b1000;
        for (int b = 0; b < 3; b++) begin
            id[1][15:8] = 8'h11 + 8'(b); il[1][1] = (b == 2);
            cyc();
            chk("lock_data", od[1], 8'h11 + b);
            chk("lock_grant", og[1], 4'b0010);
        end
        chk("lock_ptr", d1.ptr_q, 4'b0100);
        iv[1] = 4'b1000;
        cyc();
        chk("lock_after_grant", og[1], 4'b1000);
        chk("lock_after_data", od[1], 8'h33);
        iv[1] = 0;
        cyc();
        // owner gap: channel 0 idles mid-burst, channel 2 must stay blocked
        iv[1] = 4'b0101; id[1] = 32'h00C200C0; il[1] = 4'b0100;
        cyc();
        chk("gap_first", og[1], 4'b0001);
        iv[1] = 4'b0100;
        for (int k = 0; k < 2; k++) begin
            #1 chk("gap_in_ready", ir[1], 0);
            cyc();
        end
        iv[1] = 4'b0101; id[1][7:0] = 8'hC1; il[1][0] = 1;
        #1 chk("gap_resume_ready", ir[1], 4'b0001);
        cyc();
        chk("gap_owner_grant", og[1], 4'b0001);
        chk("gap_owner_data", od[1], 8'hC1);
        iv[1] = 4'b0100;
        cyc();
        chk("gap_other_grant", og[1], 4'b0100);
        chk("gap_other_data", od[1], 8'hC2);
        iv[1] = 0;
        cyc();
        // asynchronous reset while locked and holding a beat
        iv[1] = 4'b1001; id[1] = 32'hD30000D0; il[1] = 0;
        cyc();
        chk("mid_lock_grant", og[1], 4'b1000);
        ordy[1] = 0;
        #2 aresetn = 0;
        #1;
        chk("mid_rst_valid", ov[1], 0);
        chk("mid_rst_grant", og[1], 0);
        chk("mid_rst_lock", d1.lck_q, 0);
        chk("mid_rst_ptr", d1.ptr_q, 4'b0001);
        model_reset();
        @(posedge aclk); #3;
        aresetn = 1; ordy[1] = 1;
        cyc();
        chk("post_rst_grant", og[1], 4'b0001);
        chk("post_rst_data", od[1], 8'hD0);
        iv[1] = 0;
        cyc();
        // single-channel register slice with random back-pressure
        q.push_back(32'hDEADBEEF); q.push_back(32'h12345678);
        for (int c = 0; c < 60 && rx.size() < 2; c++) begin
            iv1 = q.size() > 0;
            id1 = q.size() > 0 ? q[0] : 32'h0;
            il1 = q.size() == 1;
            ordy1 = 1'($urandom_range(0, 1));
            cyc();
            if (acc1) void'(q.pop_front());
            if (del1) rx.push_back(deld1);
        end
        chk("n1_count", rx.size(), 2);
        chk("n1_first", rx.size() > 0 ? rx[0] : 32'hx, 32'hDEADBEEF);
        chk("n1_second", rx.size() > 1 ? rx[1] : 32'hx, 32'h12345678);
        // random traffic on all instances
        for (int c = 0; c < 300; c++) begin
            for (int m = 0; m < 2; m++) begin
                iv[m] = 4'($urandom); id[m] = $urandom; il[m] = 4'($urandom);
                ordy[m] = $urandom_range(0, 3) != 0;
            end
            iv1 = 1'($urandom); id1 = $urandom; il1 = 1'($urandom); ordy1 = 1'($urandom);
            cyc();
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
